// File: rtl/obi_mem_responder.sv
// OBI-style single-port memory responder with fixed response latency,
// outstanding-request limiting and wait-state injection for verification.
module obi_mem_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          DEPTH_WORDS     = 1024,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        stall_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int          IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RANGE_BYTES = 32'(DEPTH_WORDS) << 2;
  localparam logic [2:0]  MAX_CNT     = 3'(MAX_OUTSTANDING);

  generate
    if ((DEPTH_WORDS < 16) || (DEPTH_WORDS > 65536) ||
        ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) ||
        (LATENCY < 1) || (LATENCY > 4) ||
        (MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > 4)) begin : g_bad_params
      $fatal(1, "obi_mem_responder: illegal parameter combination");
    end
  endgenerate

  logic [31:0]      w_diff;
  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic             w_accept;
  logic [31:0]      w_pd0;

  logic [2:0]         r_count;
  logic               r_s0_rd;
  logic [LATENCY-1:0] r_pv;
  logic [LATENCY-1:0] r_pe;
  logic [31:0]        r_pd [LATENCY];
  logic [31:0]        r_mem [DEPTH_WORDS];
  logic [31:0]        r_rd_word;

  assign w_diff     = addr_i - BASE_ADDR;
  assign w_in_range = w_diff < RANGE_BYTES;
  assign w_idx      = w_diff[IDX_W+1:2];

  // A response leaving this cycle frees a slot, so a full counter can still grant.
  assign gnt_o    = rst_ni & req_i & ~stall_i & ((r_count < MAX_CNT) | rvalid_o);
  assign w_accept = req_i & gnt_o;

  // Memory array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (w_accept && w_in_range) begin
      if (we_i) begin
        for (int k = 0; k < 4; k++) begin
          if (be_i[k]) r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end else begin
        r_rd_word <= r_mem[w_idx];
      end
    end
  end

  // Stage-0 data is the RAM output register, zeroed unless an in-range read owns it.
  assign w_pd0 = r_s0_rd ? r_rd_word : 32'h0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= 3'd0;
      r_s0_rd <= 1'b0;
      r_pv    <= '0;
      r_pe    <= '0;
      for (int k = 0; k < LATENCY; k++) r_pd[k] <= 32'h0;
    end else begin
      r_s0_rd <= w_accept & ~we_i & w_in_range;
      r_pv[0] <= w_accept;
      r_pe[0] <= w_accept & ~w_in_range;
      for (int k = 1; k < LATENCY; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pe[k] <= r_pe[k-1];
        r_pd[k] <= (k == 1) ? w_pd0 : r_pd[k-1];
      end
      case ({w_accept, rvalid_o})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rvalid_o = r_pv[LATENCY-1];
  assign err_o    = r_pe[LATENCY-1];
  assign rdata_o  = (LATENCY == 1) ? w_pd0 : r_pd[LATENCY-1];

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed bench for obi_mem_responder (LATENCY=3, MAX_OUTSTANDING=2, 1024 words).
module tb_obi_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  int n_tests = 0;
  int n_fail  = 0;

  obi_mem_responder #(
    .BASE_ADDR(32'h0000_0000),
    .DEPTH_WORDS(1024),
    .LATENCY(3),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .stall_i(stall_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated transaction: wait for grant, then measure latency and check response.
  task automatic do_req(input string tag, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    int lat;
    req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wdata;
    #1;
    n = 0;
    while (!gnt_o && n < 20) begin
      step();
      #1;
      n++;
    end
    chk({tag, "_gnt_wait"}, n, 0);
    step();
    req_i = 1'b0;
    #1;
    lat = 1;
    while (!rvalid_o && lat < 10) begin
      step();
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_rdata"}, rdata_o, exp_rdata);
    chk({tag, "_err"}, {31'h0, err_o}, {31'h0, exp_err});
    $display("[TB] %s we=%0b be=%b addr=%h wdata=%h -> lat=%0d rdata=%h err=%0b",
             tag, we, be, addr, wdata, lat, rdata_o, err_o);
    step();
    #1;
    chk({tag, "_single_pulse"}, {31'h0, rvalid_o}, 32'h0);
  endtask

  logic [11:0] exp_gnt;
  logic [11:0] exp_rv;

  initial begin
    rst_ni = 1'b0; req_i = 1'b1; we_i = 1'b0; be_i = 4'h0;
    addr_i = 32'h10; wdata_i = 32'h0; stall_i = 1'b0;
    #1;
    chk("reset_gnt", {31'h0, gnt_o}, 32'h0);
    chk("reset_rvalid", {31'h0, rvalid_o}, 32'h0);
    chk("reset_rdata", rdata_o, 32'h0);
    chk("reset_err", {31'h0, err_o}, 32'h0);
    step(); step();
    req_i = 1'b0;
    rst_ni = 1'b1;

    // Basic, partial and out-of-range accesses.
    do_req("wr_full", 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req("rd_full", 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    do_req("wr_part", 1'b1, 4'b0010, 32'h10, 32'h0000AA00, 32'h0, 1'b0);
    do_req("rd_part", 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0);
    do_req("wr_top", 1'b1, 4'hF, 32'hFFC, 32'h12345678, 32'h0, 1'b0);
    do_req("wr_oor", 1'b1, 4'hF, 32'h1000, 32'hCAFEF00D, 32'h0, 1'b1);
    do_req("rd_top", 1'b0, 4'h0, 32'hFFE, 32'h0, 32'h12345678, 1'b0);
    do_req("rd_oor", 1'b0, 4'h0, 32'h1000, 32'h0, 32'h0, 1'b1);
    do_req("rd_low_oor", 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1);

    // Outstanding limit: req high for cycles 0..8.
    exp_gnt = 12'b0000_1101_1011;
    exp_rv  = 12'b0110_1101_1000;
    for (int c = 0; c < 12; c++) begin
      req_i = (c <= 8); we_i = 1'b0; addr_i = 32'h10;
      #1;
      chk($sformatf("limit_gnt_c%0d", c), {31'h0, gnt_o}, {31'h0, exp_gnt[c]});
      chk($sformatf("limit_rv_c%0d", c), {31'h0, rvalid_o}, {31'h0, exp_rv[c]});
      if (exp_rv[c]) chk($sformatf("limit_rdata_c%0d", c), rdata_o, 32'hDEADAAEF);
      else           chk($sformatf("limit_idle_rdata_c%0d", c), rdata_o, 32'h0);
      $display("[TB] limit cycle %0d gnt=%0b rvalid=%0b rdata=%h", c, gnt_o, rvalid_o, rdata_o);
      step();
    end

    // Stall in cycles 2-3, req high for cycles 0..4.
    exp_gnt = 12'b0000_0001_0011;
    exp_rv  = 12'b0000_1001_1000;
    for (int c = 0; c < 10; c++) begin
      req_i = (c <= 4); stall_i = (c == 2 || c == 3);
      #1;
      chk($sformatf("stall_gnt_c%0d", c), {31'h0, gnt_o}, {31'h0, exp_gnt[c]});
      chk($sformatf("stall_rv_c%0d", c), {31'h0, rvalid_o}, {31'h0, exp_rv[c]});
      $display("[TB] stall cycle %0d stall=%0b gnt=%0b rvalid=%0b", c, stall_i, gnt_o, rvalid_o);
      step();
    end
    stall_i = 1'b0;

    // Reset with two reads in flight.
    do_req("wr_pre_rst", 1'b1, 4'hF, 32'h10, 32'h5A5A1234, 32'h0, 1'b0);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10;
    #1;
    chk("rst_mid_gnt0", {31'h0, gnt_o}, 32'h1);
    step();
    #1;
    chk("rst_mid_gnt1", {31'h0, gnt_o}, 32'h1);
    step();
    req_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_rvalid", {31'h0, rvalid_o}, 32'h0);
    step();
    rst_ni = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("rst_discard_c%0d", c), {31'h0, rvalid_o}, 32'h0);
      step();
    end
    $display("[TB] reset mid-operation: pending responses discarded");

    // Short reset pulse, then a grant in the first cycle after release.
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    do_req("rd_post_rst", 1'b0, 4'h0, 32'h10, 32'h0, 32'h5A5A1234, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/obi_mem_responder.md
OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of memory word 0.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words; power of two, 16..65536.
REQ-003 The block SHALL have parameter LATENCY, default 1, cycles from grant to response; 1..4.
REQ-004 The block SHALL have parameter MAX_OUTSTANDING, default 2, maximum granted-but-unresponded requests; 1..4.
REQ-005 One clock and an asynchronous active-low reset: clk_i input 1 (clock, all state on rising edge); rst_ni input 1 (asynchronous assert, active low).
REQ-006 req_i  input  1  initiator request valid.
REQ-007 we_i  input  1  1 = write, 0 = read.
REQ-008 be_i  input  4  byte enables for writes; ignored for reads.
REQ-009 addr_i  input  32  byte address; bits [1:0] ignored.
REQ-010 wdata_i  input  32  write data.
REQ-011 stall_i  input  1  verification wait-state injection; forces gnt_o low.
REQ-012 gnt_o  output  1  request accepted this cycle.
REQ-013 rvalid_o  output  1  response valid, one cycle per granted request.
REQ-014 rdata_o  output  32  read data; 0 for writes and errors.
REQ-015 err_o  output  1  response error flag, qualified by rvalid_o.

Function
REQ-016 gnt_o SHALL be combinational: req_i & ~stall_i & (count < MAX_OUTSTANDING | rvalid_o), where count is the registered outstanding counter.
REQ-017 A request SHALL be accepted only in a cycle with req_i & gnt_o; all request fields are sampled in that cycle only.
REQ-018 Index = (addr_i - BASE_ADDR) >> 2, 32-bit unsigned subtraction; in range iff the difference < DEPTH_WORDS*4.
REQ-019 An accepted in-range write SHALL update each byte k where be_i[k]=1 at the accepting clock edge; other bytes are unchanged.
REQ-020 An accepted in-range read SHALL sample the array at the accepting edge, so it sees all writes accepted in earlier cycles.
REQ-021 An accepted out-of-range access SHALL not modify memory and SHALL respond with err_o=1 and rdata_o=0.
REQ-022 Each accepted request SHALL produce exactly one rvalid_o pulse exactly LATENCY cycles after the accepting cycle, in acceptance order; responses SHALL never be stalled.
REQ-023 Implementation: a LATENCY-deep shift pipeline of {valid, rdata, err}; stage 0 is loaded at acceptance and the last stage drives the outputs.
REQ-024 rdata_o and err_o SHALL be 0 whenever rvalid_o=0.
REQ-025 count SHALL change by +1 on acceptance and -1 on rvalid_o; it is unchanged when both occur in the same cycle; it never exceeds MAX_OUTSTANDING.
REQ-026 stall_i SHALL suppress grants only and SHALL not delay responses already in the pipeline.
REQ-027 An illegal parameter combination SHALL trigger an elaboration-time fatal assertion.

Reset
REQ-028 While rst_ni=0: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, count=0, all pipeline valid bits 0.
REQ-029 Reset mid-operation SHALL discard pending responses; no rvalid_o appears for them after release.
REQ-030 Writes accepted before reset remain in memory; memory contents are not reset.
REQ-031 A request may be granted in the first cycle after rst_ni deasserts.

Verification
REQ-032 Full write then read: write 32'hDEADBEEF, be=4'b1111, addr 0x10; then read 0x10 -> read rvalid_o exactly LATENCY cycles after its grant, rdata_o=32'hDEADBEEF, err_o=0.
REQ-033 Partial write: then write wdata 32'h0000AA00, be=4'b0010, addr 0x10; read 0x10 -> rdata_o=32'hDEADAAEF.
REQ-034 Out of range with DEPTH_WORDS=1024: write to 0x1000 -> err_o=1, rdata_o=0; read 0x0FFC is unchanged; read 0x1000 -> err_o=1.
REQ-035 Outstanding limit with LATENCY=3, MAX_OUTSTANDING=2 and req_i held high from cycle 0 -> grants in cycles 0,1,3,4,6,7; rvalid_o in cycles 3,4,6,7,9,10.
REQ-036 Stall: stall_i=1 for cycles 2-3 with req_i high -> gnt_o=0 in cycles 2-3 and grant in cycle 4; earlier responses are still delivered on schedule.
REQ-037 Reset: assert rst_ni=0 with 2 responses pending -> no rvalid_o for them; after release, a read of 0x10 returns the value written before reset.
